// File: rtl/approx_mult_seq.sv
// Iterative unsigned WxW shift-add multiplier, one multiplier bit per cycle.
// Approximate mode ORs the low APPROX_COLS columns and blocks their carries.
module approx_mult_seq #(
    parameter int W           = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           out_mode
);

    localparam int PW = 2 * W;
    localparam int IW = $clog2(W);
    // Ones over the approximated columns; all-zero when APPROX_COLS is 0.
    localparam logic [PW-1:0] LOW_MASK = ~({PW{1'b1}} << APPROX_COLS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          mode_r;
    logic [PW-1:0] acc;
    logic [IW-1:0] idx;

    logic [PW-1:0] addend;
    logic [PW-1:0] sum_exact;
    logic [PW-1:0] sum_approx;
    logic [PW-1:0] acc_next;

    // Masked high halves have zero low columns, so no carry reaches them.
    always_comb begin
        addend     = b_r[idx] ? ({{W{1'b0}}, a_r} << idx) : '0;
        sum_exact  = acc + addend;
        sum_approx = ((acc | addend) & LOW_MASK)
                   | ((acc & ~LOW_MASK) + (addend & ~LOW_MASK));
        acc_next   = mode_r ? sum_approx : sum_exact;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= 1'b0;
            acc    <= '0;
            idx    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        mode_r <= mode;
                        acc    <= '0;
                        idx    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == IW'(W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign product   = acc;
    assign out_mode  = mode_r;

endmodule
